// File: rtl/pixel_frame_store.sv
// Purpose: 128x128x3 frame memory; renderer plot port in, raster-order scan-out stream to display.
// Latency: 1-cycle synchronous read; 2 cycles per pixel (FETCH + PRESENT), frame = 32768 cycles + DONE.
// Backpressure: scan-out holds PRESENT while pixReady=0; write port never stalls.
module pixel_frame_store #(
  parameter int XBITS = 7,
  parameter int YBITS = 7,
  parameter int CBITS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XBITS:0]   xIn,
  input  logic [YBITS:0]   yIn,
  input  logic [CBITS-1:0] colourIn,
  input  logic             plot,
  input  logic             scanStart,
  input  logic             pixReady,
  output logic             pixValid,
  output logic [XBITS-1:0] pixX,
  output logic [YBITS-1:0] pixY,
  output logic [CBITS-1:0] pixColour,
  output logic             busy,
  output logic             frameDone
);

  localparam int ABITS = XBITS + YBITS;
  localparam int DEPTH = 1 << ABITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ABITS-1:0] ADDR_LAST = {ABITS{1'b1}};
  localparam logic [ABITS-1:0] ADDR_ONE  = {{(ABITS-1){1'b0}}, 1'b1};

  logic [CBITS-1:0] mem [DEPTH];
  logic [CBITS-1:0] rd_q;
  logic [1:0]       state, state_nxt;
  logic [ABITS-1:0] addr, addr_nxt;
  logic             valid_q, busy_q, done_q;
  logic             wr_en;

  // Off-screen plots (bit 7 of either coordinate) are simply not written.
  assign wr_en = plot & ~xIn[XBITS] & ~yIn[YBITS];

  // Write port: one pixel per cycle, accepted in every scan state.
  always_ff @(posedge clock) begin
    if (wr_en) mem[{yIn[YBITS-1:0], xIn[XBITS-1:0]}] <= colourIn;
  end

  // Read port: non-blocking semantics give old data on a same-address collision.
  always_ff @(posedge clock) begin
    if (state == S_FETCH) rd_q <= mem[addr];
  end

  // Scan-out next-state and address sequencing.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      S_IDLE: begin
        if (scanStart) begin
          addr_nxt  = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (pixReady) begin
          if (addr == ADDR_LAST) begin
            state_nxt = S_DONE;
          end else begin
            addr_nxt  = addr + ADDR_ONE;
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, address and registered status flags; reset aborts any scan silently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      valid_q <= (state_nxt == S_PRESENT);
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= (state_nxt == S_DONE);
    end
  end

  // Read data register is left unreset so it maps onto block RAM; it is masked
  // by the registered valid flag so colour reads 0 whenever no pixel is presented.
  assign pixColour = valid_q ? rd_q : '0;
  assign pixValid  = valid_q;
  assign pixX      = addr[XBITS-1:0];
  assign pixY      = addr[ABITS-1:XBITS];
  assign busy      = busy_q;
  assign frameDone = done_q;

endmodule
